// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    CR  = 3'b010,
    MUL = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    SLL = 3'b111
  } opcode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

endpackage

// File: rtl/alu_mul.sv
// Combinational multiplier keeping only the low N bits of the product.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU with zero/negative flags.
// Define ALU_MUL_EN to build the multiplier; otherwise MUL returns zero.
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [2:0]   opcode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         valid_o,
  output logic [N-1:0] result_o,
  output logic [1:0]   ALUFlags
);

  localparam int SW = $clog2(N);

  opcode_e      op;
  logic [N-1:0] diff;
  logic [N-1:0] mul_p;
  logic [N-1:0] res_d;
  logic [1:0]   flags_d;

  assign op   = opcode_e'(opcode_i);
  assign diff = a_i - b_i;

`ifdef ALU_MUL_EN
  alu_mul #(.N(N)) u_mul (
    .a_i (a_i),
    .b_i (b_i),
    .p_o (mul_p)
  );
`else
  assign mul_p = '0;
`endif

  // Compare derives flags from the operands directly and forces the result to zero.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (op)
      ADD:     res_d = a_i + b_i;
      SUB:     res_d = diff;
      CR:      res_d = '0;
      MUL:     res_d = mul_p;
      AND:     res_d = a_i & b_i;
      OR:      res_d = a_i | b_i;
      XOR:     res_d = a_i ^ b_i;
      SLL:     res_d = a_i << b_i[SW-1:0];
      default: res_d = '0;
    endcase
    if (op == CR) begin
      flags_d[FLAG_Z] = (diff == '0);
      flags_d[FLAG_N] = ($signed(a_i) < $signed(b_i));
    end else begin
      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_N] = res_d[N-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      ALUFlags <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        result_o <= res_d;
        ALUFlags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences,
// and randomized traffic against an arithmetic reference model.
module tb_alu;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CR  = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic [2:0]  opcode_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic [1:0]  ALUFlags;

  int compared;
  int mismatched;

  alu #(.N(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .opcode_i (opcode_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .ALUFlags (ALUFlags)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [1:0]  exp_flags;
  } vec_t;

  vec_t vecs[12];

  // Reference model: plain 64-bit arithmetic reduced modulo 2^32.
  function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic [1:0] flags);
    longint unsigned wa, wb, full;
    longint unsigned modulus;
    int unsigned     sh;
    wa = 64'(a);
    wb = 64'(b);
    modulus = 64'h1_0000_0000;
    full = 0;
    sh = b % 32;
    case (op)
      OP_ADD: full = (wa + wb) % modulus;
      OP_SUB: full = (wa + modulus - wb) % modulus;
      OP_CR:  full = 0;
`ifdef ALU_MUL_EN
      OP_MUL: full = (wa * wb) % modulus;
`else
      OP_MUL: full = 0;
`endif
      OP_AND: full = wa & wb;
      OP_OR:  full = wa | wb;
      OP_XOR: full = wa ^ wb;
      default: full = (wa * (64'd1 << sh)) % modulus;
    endcase
    res = full[31:0];
    if (op == OP_CR) begin
      flags[0] = (a == b);
      flags[1] = (int'(a) < int'(b));
    end else begin
      flags[0] = (full == 0);
      flags[1] = (full >= 64'h8000_0000);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] exp_res,
                             input logic [1:0] exp_flags, input logic exp_valid);
    compared += 3;
    if (result_o !== exp_res) begin
      mismatched++;
      $display("[TB] FAIL %s result: got %h want %h", name, result_o, exp_res);
    end
    if (ALUFlags !== exp_flags) begin
      mismatched++;
      $display("[TB] FAIL %s flags: got %b want %b", name, ALUFlags, exp_flags);
    end
    if (valid_o !== exp_valid) begin
      mismatched++;
      $display("[TB] FAIL %s valid: got %b want %b", name, valid_o, exp_valid);
    end
  endtask

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    valid_i  = v;
    opcode_i = op;
    a_i      = a;
    b_i      = b;
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] hold_res, m_res;
  logic [1:0]  hold_flags, m_flags;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_ni   = 1'b0;
    valid_i  = 1'b0;
    opcode_i = '0;
    a_i      = '0;
    b_i      = '0;

    vecs[0]  = '{"add_1_10",   OP_ADD, 32'd1,          32'd10, 32'd11,         2'b00};
    vecs[1]  = '{"sub_10_5",   OP_SUB, 32'd10,         32'd5,  32'd5,          2'b00};
    vecs[2]  = '{"sub_5_10",   OP_SUB, 32'd5,          32'd10, 32'hFFFF_FFFB,  2'b10};
    vecs[3]  = '{"cr_eq",      OP_CR,  32'd11,         32'd11, 32'd0,          2'b01};
    vecs[4]  = '{"cr_lt",      OP_CR,  32'd3,          32'd7,  32'd0,          2'b10};
`ifdef ALU_MUL_EN
    vecs[5]  = '{"mul_5_5",    OP_MUL, 32'd5,          32'd5,  32'd25,         2'b00};
`else
    vecs[5]  = '{"mul_off",    OP_MUL, 32'd5,          32'd5,  32'd0,          2'b01};
`endif
    vecs[6]  = '{"add_wrap",   OP_ADD, 32'hFFFF_FFFF,  32'd1,  32'd0,          2'b01};
    vecs[7]  = '{"sll_31",     OP_SLL, 32'd1,          32'd31, 32'h8000_0000,  2'b10};
    vecs[8]  = '{"and",        OP_AND, 32'h0000_F0F0,  32'h0000_0FF0, 32'h0000_00F0, 2'b00};
    vecs[9]  = '{"or_neg",     OP_OR,  32'h8000_0000,  32'h0000_0001, 32'h8000_0001, 2'b10};
    vecs[10] = '{"xor_self",   OP_XOR, 32'h1234_5678,  32'h1234_5678, 32'd0,         2'b01};
    vecs[11] = '{"sll_upper",  OP_SLL, 32'd3,          32'd36, 32'h0000_0030,  2'b00};

    #2;
    checkOutput("reset_state", 32'd0, 2'b00, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Back-to-back directed vectors, one per cycle.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].exp_res, vecs[i].exp_flags, 1'b1);
    end

    // Mid-stream reset after a valid ADD, with another op pending.
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd10);
    checkOutput("pre_reset_add", 32'd11, 2'b00, 1'b1);
    valid_i  = 1'b1;
    opcode_i = OP_ADD;
    a_i      = 32'd2;
    b_i      = 32'd2;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_reset", 32'd0, 2'b00, 1'b0);
    @(posedge clk_i);
    #1;
    checkOutput("reset_discard", 32'd0, 2'b00, 1'b0);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    applyStimulus(1'b0, OP_ADD, 32'd2, 32'd2);
    checkOutput("post_reset_idle", 32'd0, 2'b00, 1'b0);
    applyStimulus(1'b1, OP_ADD, 32'd2, 32'd2);
    checkOutput("post_reset_add", 32'd4, 2'b00, 1'b1);

    // Idle cycles hold the last result and drop valid_o.
    applyStimulus(1'b0, OP_SUB, 32'd1, 32'd2);
    checkOutput("hold_1", 32'd4, 2'b00, 1'b0);
    applyStimulus(1'b0, OP_XOR, 32'd7, 32'd7);
    checkOutput("hold_2", 32'd4, 2'b00, 1'b0);

    hold_res   = 32'd4;
    hold_flags = 2'b00;
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [2:0]  op;
      logic [31:0] a, b;
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = a; end
        1:       begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      applyStimulus(v, op, a, b);
      if (v) begin
        model(op, a, b, m_res, m_flags);
        hold_res   = m_res;
        hold_flags = m_flags;
      end
      checkOutput($sformatf("rand_%0d_op%0d", i, op), hold_res, hold_flags, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter N, default 32, is the operand and result width in bits; it SHALL be at least 8 and a power of two.
REQ-002 The ports SHALL be as follows; the block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
- clk_i  input  1  rising-edge clock
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  operands/opcode valid this cycle
- opcode_i  input  3  operation select
- a_i  input  N  operand A
- b_i  input  N  operand B
- valid_o  output  1  result_o/ALUFlags updated this cycle
- result_o  output  N  registered result
- ALUFlags  output  2  registered flags; [0]=Z (zero), [1]=N (negative)

Function
REQ-003 Opcode encoding SHALL be:
- 000 ADD: a+b
- 001 SUB: a-b
- 010 CR (compare)
- 011 MUL: low N bits of a*b
- 100 AND
- 101 OR
- 110 XOR
- 111 SLL: a << b[log2(N)-1:0]
REQ-004 All arithmetic SHALL be unsigned modulo 2^N; carries and overflow SHALL be discarded (0xFFFFFFFF+1 = 0).
REQ-005 CR SHALL compute a-b for flags only; result_o SHALL be 0, Z SHALL be 1 when a==b, and N SHALL be 1 when a<b as signed two's complement values.
REQ-006 For all other opcodes, Z SHALL be (result==0) and N SHALL be result[N-1].
REQ-007 Latency SHALL be one cycle: inputs sampled at rising edge k with valid_i=1 appear on result_o/ALUFlags with valid_o=1 after edge k.
REQ-008 When valid_i=0 at an edge, result_o and ALUFlags SHALL hold their previous values and valid_o SHALL be 0.
REQ-009 Back-to-back valid_i SHALL be accepted every cycle with no stall; the block SHALL have no ready signal.
REQ-010 Shift amounts of N-1 or less SHALL be exact; upper bits of b_i SHALL be ignored for SLL.

Reset
REQ-011 When rst_ni=0, result_o, ALUFlags and valid_o SHALL go to 0 immediately, independent of clk_i.
REQ-012 An operation sampled in the cycle reset asserts SHALL be discarded; the first valid_i after rst_ni rises SHALL be processed normally.

Configuration
REQ-013 With macro ALU_MUL_EN defined, MUL SHALL be implemented per REQ-003.
REQ-014 Without ALU_MUL_EN, no multiplier SHALL be synthesized, MUL SHALL return result_o=0 with Z=1 and N=0, and valid_o SHALL still assert.

Structure
REQ-015 Package alu_pkg SHALL hold the opcode enum (ADD, SUB, CR, MUL, AND, OR, XOR, SLL) and the flag bit index constants FLAG_Z=0 and FLAG_N=1.
REQ-016 The multiplier SHALL be a sub-module alu_mul, instantiated only under ALU_MUL_EN; all other logic SHALL remain in alu.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- ADD a=1, b=10 -> result_o=11, ALUFlags=00, valid_o=1 one cycle later
- SUB a=10, b=5 -> result_o=5, ALUFlags=00; SUB a=5, b=10 -> result_o=0xFFFFFFFB, ALUFlags=10
- CR a=11, b=11 -> result_o=0, ALUFlags=01; CR a=3, b=7 -> ALUFlags=10
- MUL a=5, b=5 -> 25 with ALU_MUL_EN; without ALU_MUL_EN -> result_o=0, ALUFlags=01
- ADD a=0xFFFFFFFF, b=1 -> result_o=0, ALUFlags=01; SLL a=1, b=31 -> result_o=0x80000000, ALUFlags=10
- assert rst_ni mid-stream after a valid ADD -> outputs 0 immediately; valid_i=0 cycles -> outputs hold and valid_o=0
